btb_next_pc: RTL and testbench



---
 rtl/cpu_pred_pkg.sv | 28 ++
 rtl/btb_array.sv | 47 ++++
 rtl/btb_next_pc.sv | 82 ++++++++
 tb/tb_btb_next_pc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pred_pkg.sv
// Shared types and constants for the fetch-side prediction path.
// pred_meta_t is the per-instruction record carried from IF down to EX.
package cpu_pred_pkg;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          BTB_ENTRIES  = 32;
  localparam int          BTB_IDX_BITS = 5;
  localparam int          BTB_TAG_BITS = 30 - BTB_IDX_BITS;
  // Widest tag any legal index width can produce; narrower tags are zero-extended.
  localparam int          BTB_TAG_MAX  = 30;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
  } btb_entry_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] pred_next;
  } pred_meta_t;

  function automatic logic [31:0] pc_plus_inc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: asynchronous read of one entry, one synchronous
// write port. Only the valid bits are reset; tag/target contents are don't-care.
module btb_array
  import cpu_pred_pkg::*;
#(
  parameter int ENTRIES  = BTB_ENTRIES,
  parameter int IDX_BITS = BTB_IDX_BITS,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output btb_entry_t          rd_entry,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target
);

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [31:0]         tgt_mem [ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  // Read is taken from the registered arrays, so a same-cycle write is not seen.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid[rd_idx];
    rd_entry.tag    = BTB_TAG_MAX'(tag_mem[rd_idx]);
    rd_entry.target = tgt_mem[rd_idx];
  end

endmodule

// File: rtl/btb_next_pc.sv
// Next-PC generator: BTB lookup plus direction prediction forms next_pc, the
// prediction rides IF->ID->EX, and EX raises a redirect when it was wrong.
module btb_next_pc
  import cpu_pred_pkg::*;
#(
  parameter int ENTRIES  = BTB_ENTRIES,
  parameter int IDX_BITS = BTB_IDX_BITS,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic        pred_taken,
  input  logic        Hazard,
  input  logic        update,
  input  logic        real_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] next_pc,
  output logic        btb_hit,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  btb_entry_t          lookup;
  logic [IDX_BITS-1:0] cur_idx;
  logic [TAG_BITS-1:0] cur_tag;
  logic [31:0]         pred_next;

  pred_meta_t          id_q;
  pred_meta_t          ex_q;
  logic                ex_taken;
  logic [31:0]         actual_next;
  logic                btb_wr;

  assign cur_idx = current_pc[IDX_BITS+1:2];
  assign cur_tag = current_pc[31:IDX_BITS+2];

  btb_array #(
    .ENTRIES  (ENTRIES),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (cur_idx),
    .rd_entry  (lookup),
    .wr_en     (btb_wr),
    .wr_idx    (ex_q.pc[IDX_BITS+1:2]),
    .wr_tag    (ex_q.pc[31:IDX_BITS+2]),
    .wr_target (ex_target)
  );

  always_comb begin
    btb_hit   = lookup.valid && (lookup.tag == BTB_TAG_MAX'(cur_tag));
    pred_next = (btb_hit && pred_taken) ? lookup.target : pc_plus_inc(current_pc);
  end

  // EX resolution; an empty EX slot resolves to fall-through and never redirects.
  always_comb begin
    ex_taken    = ex_q.v && update && real_taken;
    actual_next = ex_taken ? ex_target : pc_plus_inc(ex_q.pc);
    mispredict  = ex_q.v && (actual_next != ex_q.pred_next);
    redirect_pc = actual_next;
    next_pc     = mispredict ? redirect_pc : pred_next;
    btb_wr      = ex_taken;
  end

  // A redirect squashes both younger slots even while the pipe is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (mispredict) begin
      id_q.v <= 1'b0;
      ex_q.v <= 1'b0;
    end else if (!Hazard) begin
      id_q <= '{v: 1'b1, pc: current_pc, pred_next: pred_next};
      ex_q <= id_q;
    end
  end

endmodule

// File: tb/tb_btb_next_pc.sv
// Bench for btb_next_pc: directed vector table, an asynchronous-reset sequence,
// then random traffic checked against a queue-and-array reference model.
module tb_btb_next_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        pred_taken;
  logic        Hazard;
  logic        update;
  logic        real_taken;
  logic [31:0] ex_target;
  logic [31:0] next_pc;
  logic        btb_hit;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btb_next_pc dut (
    .clk         (clk),
    .reset       (reset),
    .current_pc  (current_pc),
    .pred_taken  (pred_taken),
    .Hazard      (Hazard),
    .update      (update),
    .real_taken  (real_taken),
    .ex_target   (ex_target),
    .next_pc     (next_pc),
    .btb_hit     (btb_hit),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        pt, hz, upd, rt;
    logic [31:0] tgt;
    logic [31:0] e_next;
    logic        e_hit, e_mis;
    logic [31:0] e_redir;
    logic        chk_redir;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [31:0] pc, input logic pt,
                              input logic hz, input logic upd, input logic rt,
                              input logic [31:0] tgt, input logic [31:0] e_next,
                              input logic e_hit, input logic e_mis,
                              input logic [31:0] e_redir, input logic chk_redir);
    vec_t v;
    v.rst = rst; v.pc = pc; v.pt = pt; v.hz = hz; v.upd = upd; v.rt = rt; v.tgt = tgt;
    v.e_next = e_next; v.e_hit = e_hit; v.e_mis = e_mis; v.e_redir = e_redir;
    v.chk_redir = chk_redir;
    return v;
  endfunction

  // Reference model: the BTB as arrays keyed by word index, in-flight fetches as a queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
  } rec_t;

  rec_t        pipe[$];
  bit          m_v   [32];
  logic [31:0] m_pc  [32];
  logic [31:0] m_tgt [32];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
  endtask

  vec_t tbl[21];

  logic [31:0] pool[8];

  initial begin
    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0180; pool[2] = 32'h0000_0104;
    pool[3] = 32'h0000_0200; pool[4] = 32'h0000_0300; pool[5] = 32'h1000_0100;
    pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h0000_0204;

    tbl[0]  = mk(1, 32'h100, 1, 0, 0, 0, 32'h0,   32'h104, 0, 0, 32'h4,   1);
    tbl[1]  = mk(0, 32'h100, 1, 0, 0, 0, 32'h0,   32'h104, 0, 0, 32'h0,   0);
    tbl[2]  = mk(0, 32'h104, 0, 0, 0, 0, 32'h0,   32'h108, 0, 0, 32'h0,   0);
    tbl[3]  = mk(0, 32'h100, 1, 0, 1, 1, 32'h200, 32'h200, 0, 1, 32'h200, 1);
    tbl[4]  = mk(0, 32'h200, 0, 0, 0, 0, 32'h0,   32'h204, 0, 0, 32'h0,   0);
    tbl[5]  = mk(0, 32'h100, 1, 0, 0, 0, 32'h0,   32'h200, 1, 0, 32'h0,   0);
    tbl[6]  = mk(0, 32'h200, 0, 0, 0, 0, 32'h0,   32'h204, 0, 0, 32'h0,   0);
    tbl[7]  = mk(0, 32'h204, 0, 0, 1, 0, 32'h200, 32'h104, 0, 1, 32'h104, 1);
    tbl[8]  = mk(0, 32'h100, 1, 0, 0, 0, 32'h0,   32'h200, 1, 0, 32'h0,   0);
    tbl[9]  = mk(0, 32'h180, 1, 0, 0, 0, 32'h0,   32'h184, 0, 0, 32'h0,   0);
    tbl[10] = mk(0, 32'h184, 0, 1, 1, 1, 32'h200, 32'h188, 0, 0, 32'h0,   0);
    tbl[11] = mk(0, 32'h184, 0, 1, 1, 1, 32'h200, 32'h188, 0, 0, 32'h0,   0);
    tbl[12] = mk(0, 32'h184, 0, 1, 1, 1, 32'h200, 32'h188, 0, 0, 32'h0,   0);
    tbl[13] = mk(0, 32'h184, 0, 0, 1, 1, 32'h200, 32'h188, 0, 0, 32'h0,   0);
    tbl[14] = mk(0, 32'h188, 0, 0, 1, 1, 32'h300, 32'h300, 0, 1, 32'h300, 1);
    tbl[15] = mk(0, 32'h300, 0, 0, 0, 0, 32'h0,   32'h304, 0, 0, 32'h0,   0);
    tbl[16] = mk(0, 32'h304, 0, 0, 0, 0, 32'h0,   32'h308, 0, 0, 32'h0,   0);
    tbl[17] = mk(0, 32'h308, 0, 1, 1, 1, 32'h400, 32'h400, 0, 1, 32'h400, 1);
    tbl[18] = mk(0, 32'h400, 0, 1, 0, 0, 32'h0,   32'h404, 0, 0, 32'h0,   0);
    tbl[19] = mk(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    tbl[20] = mk(0, 32'h404, 0, 0, 0, 0, 32'h0,   32'h408, 0, 0, 32'h0,   0);

    for (int i = 0; i < 21; i++) begin
      reset      = tbl[i].rst;
      current_pc = tbl[i].pc;
      pred_taken = tbl[i].pt;
      Hazard     = tbl[i].hz;
      update     = tbl[i].upd;
      real_taken = tbl[i].rt;
      ex_target  = tbl[i].tgt;
      #4;
      chk($sformatf("vec%0d next_pc", i), next_pc, tbl[i].e_next);
      chk($sformatf("vec%0d btb_hit", i), 32'(btb_hit), 32'(tbl[i].e_hit));
      chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
      if (tbl[i].chk_redir)
        chk($sformatf("vec%0d redirect_pc", i), redirect_pc, tbl[i].e_redir);
      @(posedge clk);
      #1;
    end

    // EX holds 0xFFFFFFFC predicted to 0; resolve it taken, then yank reset.
    current_pc = 32'h300; pred_taken = 1'b1; Hazard = 1'b0;
    update = 1'b1; real_taken = 1'b1; ex_target = 32'h500;
    #2;
    chk("pre_rst mispredict", 32'(mispredict), 32'd1);
    chk("pre_rst redirect_pc", redirect_pc, 32'h500);
    chk("pre_rst btb_hit", 32'(btb_hit), 32'd1);
    chk("pre_rst next_pc", next_pc, 32'h500);
    reset = 1'b1;
    #1;
    chk("async_rst mispredict", 32'(mispredict), 32'd0);
    chk("async_rst redirect_pc", redirect_pc, 32'h4);
    chk("async_rst btb_hit", 32'(btb_hit), 32'd0);
    chk("async_rst next_pc", next_pc, 32'h304);
    current_pc = 32'h100;
    #1;
    chk("rst_lookup next_pc", next_pc, 32'h104);
    @(posedge clk);
    #1;
    reset = 1'b0; Hazard = 1'b1; update = 1'b0; current_pc = 32'h300;
    #3;
    chk("post_rst btb_hit", 32'(btb_hit), 32'd0);
    chk("post_rst next_pc", next_pc, 32'h304);
    model_reset();
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      logic        e_hit;
      logic [31:0] e_pred;
      logic [31:0] act;
      logic        e_mis;
      logic        ex_ok;
      int          ix;

      current_pc = pool[$urandom_range(7)];
      pred_taken = ($urandom_range(9) < 7);
      Hazard     = ($urandom_range(3) == 0);
      update     = ($urandom_range(1) == 1);
      real_taken = ($urandom_range(9) < 6);
      ex_target  = pool[$urandom_range(7)];
      #3;

      ix     = slot(current_pc);
      e_hit  = m_v[ix] && ((m_pc[ix] >> 2) == (current_pc >> 2));
      e_pred = (e_hit && pred_taken) ? m_tgt[ix] : current_pc + 32'd4;
      ex_ok  = (pipe.size() == 2);
      act    = 32'h0;
      e_mis  = 1'b0;
      if (ex_ok) begin
        act   = (update && real_taken) ? ex_target : pipe[1].pc + 32'd4;
        e_mis = (act != pipe[1].pred);
      end

      chk("rnd btb_hit", 32'(btb_hit), 32'(e_hit));
      chk("rnd mispredict", 32'(mispredict), 32'(e_mis));
      chk("rnd next_pc", next_pc, e_mis ? act : e_pred);
      if (e_mis) chk("rnd redirect_pc", redirect_pc, act);

      if (ex_ok && update && real_taken) begin
        m_v[slot(pipe[1].pc)]   = 1'b1;
        m_pc[slot(pipe[1].pc)]  = pipe[1].pc;
        m_tgt[slot(pipe[1].pc)] = ex_target;
      end
      if (e_mis) begin
        pipe.delete();
      end else if (!Hazard) begin
        pipe.push_front('{pc: current_pc, pred: e_pred});
        if (pipe.size() > 2) void'(pipe.pop_back());
      end

      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
